// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read adapter: issues rinc, captures rdata one cycle later.
// Optional `level` port (occ + inflight) exists when FWFT_LEVEL_EN is defined.
module fifo_rd_fwft #(
  parameter int DATA = 8
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            rempty,
  input  logic [DATA-1:0] rdata,
  output logic            rinc,
  output logic            m_valid,
  output logic [DATA-1:0] m_data,
  input  logic            m_ready
`ifdef FWFT_LEVEL_EN
  ,
  output logic [1:0]      level
`endif
);

  logic            run;
  logic            inflight;
  logic [1:0]      occ;
  logic [DATA-1:0] buf0;
  logic [DATA-1:0] buf1;

  logic            pop;
  logic [2:0]      fill;
  logic [1:0]      slot;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf0;
  assign pop     = m_valid & m_ready;

  // Words held after this cycle's pop, counting the one arriving now.
  assign fill = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign slot = occ - {1'b0, pop};
  assign rinc = run & ~rempty & (fill < 3'd2);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
    end else begin
      run      <= 1'b1;
      inflight <= rinc;
      occ      <= fill[1:0];
    end
  end

  // Shift on pop first; a capture then lands in the first free slot.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      if (pop) begin
        buf0 <= buf1;
      end
      if (inflight) begin
        if (slot == 2'd0) begin
          buf0 <= rdata;
        end else begin
          buf1 <= rdata;
        end
      end
    end
  end

`ifdef FWFT_LEVEL_EN
  assign level = occ + {1'b0, inflight};
`endif

  a_no_overflow: assert property (
    @(posedge rclk) disable iff (!rrst_n)
    !(inflight && (occ == 2'd2) && !pop)
  );

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Directed bench for fifo_rd_fwft with a pointer/memory model of the read side.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fifo_rd_fwft;

  logic       rclk;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
`ifdef FWFT_LEVEL_EN
  logic [1:0] level;
`endif

  logic [7:0] mem [256];
  logic [7:0] wptr;
  logic [7:0] rptr;
  logic       force_empty;

  int checks;
  int errors;

  fifo_rd_fwft #(.DATA(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
`ifdef FWFT_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  assign rempty = (rptr == wptr) | force_empty;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rptr <= 8'd0;
    end else if (rinc && !rempty) begin
      rdata <= mem[rptr];
      rptr  <= rptr + 8'd1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wptr] = d;
    wptr = wptr + 8'd1;
  endtask

  task automatic test_reset;
    rrst_n = 1'b0;
    m_ready = 1'b0;
    force_empty = 1'b0;
    wptr = 8'd0;
    rdata = 8'd0;
    repeat (2) @(negedge rclk);
    #1;
    checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold rinc=%b m_valid=%b m_data=%h want 0 0 00",
               rinc, m_valid, m_data);
    end
`ifdef FWFT_LEVEL_EN
    checks++;
    if (level !== 2'd0) begin
      errors++;
      $display("FAIL reset_level got %0d want 0", level);
    end
`endif
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (rinc !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
        errors++;
        $display("FAIL idle c=%0d rinc=%b m_valid=%b m_data=%h want 0 0 00",
                 c, rinc, m_valid, m_data);
      end
      @(negedge rclk);
    end
  endtask

  task automatic test_single;
    m_ready = 1'b1;
    push(8'hA5);
    #1;
    checks++;
    if (rinc !== 1'b1) begin
      errors++;
      $display("FAIL single_issue rinc got %b want 1", rinc);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n1 rinc=%b m_valid=%b want 0 0", rinc, m_valid);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_n2 m_valid=%b m_data=%h want 1 a5", m_valid, m_data);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n3 m_valid got %b want 0", m_valid);
    end
    @(negedge rclk);
  endtask

  task automatic test_stream;
    int nreads;
    nreads = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int c = 0; c < 18; c++) begin
      #1;
      if (rinc === 1'b1) nreads++;
      if (c >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'(c - 2)) begin
          errors++;
          $display("FAIL stream c=%0d m_valid=%b m_data=%h want 1 %h",
                   c, m_valid, m_data, 8'(c - 2));
        end
      end
      @(negedge rclk);
    end
    #1;
    checks++;
    if (nreads != 16 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end reads=%0d m_valid=%b want 16 0", nreads, m_valid);
    end
    @(negedge rclk);
  endtask

  task automatic test_backpressure;
    int nreads;
    int k;
    nreads = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    for (int c = 0; c < 8; c++) begin
      #1;
      if (rinc === 1'b1) nreads++;
      if (c >= 2) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h10) begin
          errors++;
          $display("FAIL bp_hold c=%0d m_valid=%b m_data=%h want 1 10",
                   c, m_valid, m_data);
        end
      end
      @(negedge rclk);
    end
    checks++;
    if (nreads != 2) begin
      errors++;
      $display("FAIL bp_reads got %0d want 2", nreads);
    end
`ifdef FWFT_LEVEL_EN
    #1;
    checks++;
    if (level !== 2'd2) begin
      errors++;
      $display("FAIL bp_level got %0d want 2", level);
    end
`endif
    m_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 8'(8'h10 + k)) begin
          errors++;
          $display("FAIL bp_order k=%0d got %h want %h", k, m_data, 8'(8'h10 + k));
        end
        k++;
      end
      @(negedge rclk);
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL bp_count got %0d want 4", k);
    end
  endtask

  task automatic test_empty_race;
    int nreads;
    int got;
    int k;
    nreads = 0;
    got = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    #1;
    checks++;
    if (rinc !== 1'b1) begin
      errors++;
      $display("FAIL race_issue rinc got %b want 1", rinc);
    end
    @(negedge rclk);
    force_empty = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rinc === 1'b1) nreads++;
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 8'h20) begin
          errors++;
          $display("FAIL race_word got %h want 20", m_data);
        end
        got++;
      end
      @(negedge rclk);
    end
    checks++;
    if (nreads != 0 || got != 1) begin
      errors++;
      $display("FAIL race_count reads=%0d words=%0d want 0 1", nreads, got);
    end
    force_empty = 1'b0;
    k = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 8'(8'h20 + k)) begin
          errors++;
          $display("FAIL race_drain k=%0d got %h want %h", k, m_data, 8'(8'h20 + k));
        end
        k++;
      end
      @(negedge rclk);
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL race_drain_count got %0d want 4", k);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    repeat (2) @(negedge rclk);
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h30 || rinc !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre m_valid=%b m_data=%h rinc=%b want 1 30 0",
               m_valid, m_data, rinc);
    end
    rrst_n = 1'b0;
    wptr = 8'd0;
    #1;
    checks++;
    if (rinc !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_async rinc=%b m_valid=%b m_data=%h want 0 0 00",
               rinc, m_valid, m_data);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    #1;
    checks++;
    if (rinc !== 1'b0) begin
      errors++;
      $display("FAIL mid_norun rinc got %b want 0", rinc);
    end
    @(negedge rclk);
    #1;
    checks++;
    if (rinc !== 1'b1) begin
      errors++;
      $display("FAIL mid_resume rinc got %b want 1", rinc);
    end
    m_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m_valid === 1'b1) begin
        checks++;
        if (m_data !== 8'(8'h40 + k)) begin
          errors++;
          $display("FAIL mid_order k=%0d got %h want %h", k, m_data, 8'(8'h40 + k));
        end
        k++;
      end
      @(negedge rclk);
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL mid_count got %0d want 4", k);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_empty_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
